// File: rtl/daa_booth_sequencer.sv
// Control sequencer for the DAA MAC datapath: latches one signed weight and an activation,
// then streams overlapping radix-4 Booth windows LSB digit first with clear/enable/slot control.
module daa_booth_sequencer #(
  parameter int NDIG      = 9,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*NDIG-1:0] weight,
  input  logic [3:0]        act,
  input  logic              act_signed,
  input  logic              hold,
  input  logic              abort,
  output logic [2:0]        w,
  output logic [3:0]        in_pe,
  output logic              sign_ex_en,
  output logic              nep,
  output logic [3:0]        ep_count,
  output logic              clear,
  output logic              enable,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] w;
    logic [3:0] in_pe;
    logic       sign_ex_en;
    logic       nep;
    logic [3:0] ep_count;
    logic       clear;
    logic       enable;
    logic       ready;
    logic       busy;
    logic       done;
  } outs_t;

  localparam logic [3:0] LAST_DIGIT = 4'(NDIG - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC);
  localparam logic [3:0] EP_NONE    = 4'hF;

  state_t              state_r;
  logic [3:0]          digit_r;
  logic [3:0]          drain_cnt_r;
  logic [2*NDIG-1:0]   weight_r;
  logic [3:0]          act_r;
  logic                act_signed_r;
  outs_t               outs_r;

  // Window {W[2d+1],W[2d],W[2d-1]}; the appended zero supplies W[-1].
  function automatic logic [2:0] booth_window(input logic [2*NDIG-1:0] wt, input logic [3:0] idx);
    logic [2*NDIG:0] ext;
    ext = {wt, 1'b0} >> {idx, 1'b0};
    return ext[2:0];
  endfunction

  function automatic outs_t f_idle();
    outs_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Datapath flop clear is enable-gated, so enable rides along with clear.
  function automatic outs_t f_clr();
    outs_t o;
    o        = '0;
    o.clear  = 1'b1;
    o.enable = 1'b1;
    o.busy   = 1'b1;
    return o;
  endfunction

  function automatic outs_t f_run(input logic [2:0] win, input logic [3:0] ep,
                                  input logic [3:0] a, input logic sx);
    outs_t o;
    o            = '0;
    o.w          = win;
    o.ep_count   = ep;
    o.in_pe      = a;
    o.sign_ex_en = sx;
    o.nep        = 1'b1;
    o.enable     = 1'b1;
    o.busy       = 1'b1;
    return o;
  endfunction

  // Slot index F selects no save slot while the pipeline drains.
  function automatic outs_t f_drain(input logic [3:0] a, input logic sx);
    outs_t o;
    o            = '0;
    o.ep_count   = EP_NONE;
    o.in_pe      = a;
    o.sign_ex_en = sx;
    o.enable     = 1'b1;
    o.busy       = 1'b1;
    return o;
  endfunction

  function automatic outs_t f_done();
    outs_t o;
    o      = '0;
    o.done = 1'b1;
    return o;
  endfunction

  // Sequencer state, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      digit_r      <= 4'd0;
      drain_cnt_r  <= 4'd0;
      weight_r     <= '0;
      act_r        <= 4'd0;
      act_signed_r <= 1'b0;
      outs_r       <= f_idle();
    end else if (abort) begin
      state_r     <= S_IDLE;
      digit_r     <= 4'd0;
      drain_cnt_r <= 4'd0;
      outs_r      <= f_idle();
    end else if (hold && (state_r == S_CLR || state_r == S_RUN || state_r == S_DRAIN)) begin
      outs_r.enable <= 1'b0;
      outs_r.nep    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            weight_r     <= weight;
            act_r        <= act;
            act_signed_r <= act_signed;
            digit_r      <= 4'd0;
            drain_cnt_r  <= 4'd0;
            state_r      <= S_CLR;
            outs_r       <= f_clr();
          end else begin
            outs_r <= f_idle();
          end
        end
        S_CLR: begin
          digit_r <= 4'd0;
          state_r <= S_RUN;
          outs_r  <= f_run(booth_window(weight_r, 4'd0), 4'd0, act_r, act_signed_r);
        end
        S_RUN: begin
          if (digit_r == LAST_DIGIT) begin
            if (DRAIN_CYC > 0) begin
              drain_cnt_r <= 4'd1;
              state_r     <= S_DRAIN;
              outs_r      <= f_drain(act_r, act_signed_r);
            end else begin
              state_r <= S_DONE;
              outs_r  <= f_done();
            end
          end else begin
            digit_r <= digit_r + 4'd1;
            outs_r  <= f_run(booth_window(weight_r, digit_r + 4'd1), digit_r + 4'd1,
                             act_r, act_signed_r);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_r >= DRAIN_LAST) begin
            state_r <= S_DONE;
            outs_r  <= f_done();
          end else begin
            drain_cnt_r <= drain_cnt_r + 4'd1;
            outs_r      <= f_drain(act_r, act_signed_r);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          outs_r  <= f_idle();
        end
        default: begin
          state_r <= S_IDLE;
          outs_r  <= f_idle();
        end
      endcase
    end
  end

  assign w          = outs_r.w;
  assign in_pe      = outs_r.in_pe;
  assign sign_ex_en = outs_r.sign_ex_en;
  assign nep        = outs_r.nep;
  assign ep_count   = outs_r.ep_count;
  assign clear      = outs_r.clear;
  assign enable     = outs_r.enable;
  assign ready      = outs_r.ready;
  assign busy       = outs_r.busy;
  assign done       = outs_r.done;

endmodule

// File: tb/tb_daa_booth_sequencer.sv
// Bench for daa_booth_sequencer: directed and random operations checked cycle by cycle
// against an expected output trace built from the Booth recoding rules.
module tb_daa_booth_sequencer;

  localparam int NDIG      = 9;
  localparam int DRAIN_CYC = 2;
  localparam int WB        = 2 * NDIG;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, act_signed, hold, abort;
  logic [WB-1:0] weight;
  logic [3:0]    act;
  logic [2:0]    w;
  logic [3:0]    in_pe, ep_count;
  logic          sign_ex_en, nep, clear, enable, ready, busy, done;

  daa_booth_sequencer #(.NDIG(NDIG), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .weight(weight), .act(act),
    .act_signed(act_signed), .hold(hold), .abort(abort), .w(w), .in_pe(in_pe),
    .sign_ex_en(sign_ex_en), .nep(nep), .ep_count(ep_count), .clear(clear),
    .enable(enable), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One expected cycle: inputs applied before the edge, outputs expected after it.
  typedef struct packed {
    logic       start, hold, abort;
    logic       chk_pe, chk_rest, is_run, is_done;
    logic [2:0] w;
    logic [3:0] in_pe;
    logic       sx, nep;
    logic [3:0] ep;
    logic       clear, enable, ready, busy, done;
  } step_t;

  step_t         q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  longint        op_val;
  logic [WB-1:0] rw;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference window: bits 2d+1..2d-1 of the weight, read arithmetically from 2*W.
  function automatic logic [2:0] exp_w(input logic [WB-1:0] wt, input int d);
    longint u;
    u = longint'(wt) * 2;
    return 3'((u / (longint'(1) << (2 * d))) % 8);
  endfunction

  function automatic step_t s_idle();
    step_t s;
    s = '0; s.ready = 1'b1; s.chk_pe = 1'b1; s.chk_rest = 1'b1;
    return s;
  endfunction

  function automatic step_t s_clr();
    step_t s;
    s = '0; s.clear = 1'b1; s.enable = 1'b1; s.busy = 1'b1; s.chk_rest = 1'b1;
    return s;
  endfunction

  function automatic step_t s_run(input logic [WB-1:0] wt, input int d,
                                  input logic [3:0] a, input logic sg);
    step_t s;
    s = '0; s.w = exp_w(wt, d); s.ep = 4'(d); s.nep = 1'b1; s.enable = 1'b1;
    s.busy = 1'b1; s.in_pe = a; s.sx = sg; s.chk_pe = 1'b1; s.chk_rest = 1'b1;
    s.is_run = 1'b1;
    return s;
  endfunction

  function automatic step_t s_drain();
    step_t s;
    s = '0; s.ep = 4'hF; s.enable = 1'b1; s.busy = 1'b1; s.chk_rest = 1'b1;
    return s;
  endfunction

  function automatic step_t s_done();
    step_t s;
    s = '0; s.done = 1'b1; s.is_done = 1'b1;
    return s;
  endfunction

  task automatic build_op(input logic [WB-1:0] wt, input logic [3:0] a, input logic sg,
                          input int hold_d, input int hold_len, input int restart_d,
                          input int abort_d);
    step_t st;
    op_val = longint'($signed(wt));
    st = s_clr(); st.start = 1'b1; q.push_back(st);
    for (int d = 0; d < NDIG; d++) begin
      st = s_run(wt, d, a, sg);
      if (restart_d >= 0 && d == restart_d + 1) st.start = 1'b1;
      q.push_back(st);
      if (d == abort_d) begin
        st = s_idle(); st.abort = 1'b1; q.push_back(st);
        return;
      end
      if (d == hold_d) begin
        for (int h = 0; h < hold_len; h++) begin
          st = s_run(wt, d, a, sg); st.nep = 1'b0; st.enable = 1'b0; st.hold = 1'b1;
          q.push_back(st);
        end
      end
    end
    for (int k = 0; k < DRAIN_CYC; k++) q.push_back(s_drain());
    q.push_back(s_done());
  endtask

  task automatic run_queue();
    longint acc = 0;
    foreach (q[i]) begin
      start = q[i].start; hold = q[i].hold; abort = q[i].abort;
      @(posedge clk); #1;
      start = 1'b0; hold = 1'b0; abort = 1'b0;
      weight = WB'($urandom); act = 4'($urandom); act_signed = 1'($urandom);
      check("ready", 64'(ready), 64'(q[i].ready));
      check("busy", 64'(busy), 64'(q[i].busy));
      check("enable", 64'(enable), 64'(q[i].enable));
      check("done", 64'(done), 64'(q[i].done));
      if (q[i].chk_rest) begin
        check("w", 64'(w), 64'(q[i].w));
        check("nep", 64'(nep), 64'(q[i].nep));
        check("ep_count", 64'(ep_count), 64'(q[i].ep));
        check("clear", 64'(clear), 64'(q[i].clear));
      end
      if (q[i].chk_pe) begin
        check("in_pe", 64'(in_pe), 64'(q[i].in_pe));
        check("sign_ex_en", 64'(sign_ex_en), 64'(q[i].sx));
      end
      if (q[i].is_run && q[i].nep)
        acc += longint'(int'(w[1]) + int'(w[0]) - 2 * int'(w[2])) * (longint'(1) << (2 * int'(ep_count)));
      if (q[i].is_done) check("digit_sum", 64'(acc), 64'(op_val));
    end
    q.delete();
  endtask

  task automatic do_op(input logic [WB-1:0] wt, input logic [3:0] a, input logic sg,
                       input int hold_d, input int hold_len, input int restart_d,
                       input int abort_d);
    weight = wt; act = a; act_signed = sg;
    build_op(wt, a, sg, hold_d, hold_len, restart_d, abort_d);
    q.push_back(s_idle());
    run_queue();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    weight = '0; act = 4'd0; act_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_w", 64'(w), 64'd0);
    check("rst_nep", 64'(nep), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_clear", 64'(clear), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_ep", 64'(ep_count), 64'd0);
    rst = 1'b1;
    q.push_back(s_idle()); q.push_back(s_idle());
    run_queue();

    do_op(18'h00006, 4'h5, 1'b0, -1, 0, -1, -1);
    do_op(18'h3FFFF, 4'hA, 1'b1, -1, 0, -1, -1);
    do_op(18'h2A5C3, 4'h7, 1'b1, 3, 2, -1, -1);
    do_op(18'h1F0E1, 4'h3, 1'b0, -1, 0, 5, -1);
    do_op(18'h20000, 4'hC, 1'b1, -1, 0, -1, 4);
    do_op(18'h1FFFF, 4'h9, 1'b0, -1, 0, -1, -1);

    // Asynchronous reset in the middle of RUN.
    weight = 18'h12345; act = 4'h6; act_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_ready", 64'(ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_w", 64'(w), 64'd0);
    check("arst_nep", 64'(nep), 64'd0);
    check("arst_ep", 64'(ep_count), 64'd0);
    check("arst_enable", 64'(enable), 64'd0);
    check("arst_in_pe", 64'(in_pe), 64'd0);
    check("arst_sx", 64'(sign_ex_en), 64'd0);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(s_idle());
    run_queue();

    for (int r = 0; r < 8; r++) begin
      rw = WB'($urandom);
      do_op(rw, 4'($urandom), 1'($urandom),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NDIG - 1)) : -1,
            int'($urandom_range(1, 3)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NDIG - 2)) : -1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NDIG - 1)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
